// File: rtl/sram_id_table_writer_if.sv
// Request, comparator and SRAM-write signals of the ID table writer.
// slave = the writer block; master = its surroundings (front end, comparator, SRAM port).
interface sram_id_table_writer_if #(
  parameter int NUM_SLOTS  = 14,
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 19
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ID_WIDTH-1:0]     req_id;
  logic [NUM_SLOTS-1:0]    ena;
  logic [ID_WIDTH-1:0]     packet_in_ID;
  logic [2*NUM_SLOTS-1:0]  comp_result;
  logic                    sram_wr_req;
  logic [ADDR_WIDTH-1:0]   sram_wr_addr;
  logic [ID_WIDTH-1:0]     sram_wr_data;
  logic                    sram_wr_ack;
  logic                    resp_valid;
  logic [3:0]              resp_slot;
  logic [1:0]              resp_status;

  modport master (
    output req_valid, req_id, comp_result, sram_wr_ack,
    input  req_ready, ena, packet_in_ID, sram_wr_req, sram_wr_addr, sram_wr_data,
           resp_valid, resp_slot, resp_status
  );

  modport slave (
    input  req_valid, req_id, comp_result, sram_wr_ack,
    output req_ready, ena, packet_in_ID, sram_wr_req, sram_wr_addr, sram_wr_data,
           resp_valid, resp_slot, resp_status
  );
endinterface

// File: rtl/sram_id_table_writer.sv
// ID table writer: broadcasts an ID to the slot comparators, then resolves the
// registered per-slot results into hit / insert-into-lowest-empty / full.

module sram_id_slot_dec (
  input  logic [1:0] code,
  output logic       is_match,
  output logic       is_empty
);
  // code 3 is deliberately neither match nor empty
  assign is_match = (code == 2'd1);
  assign is_empty = (code == 2'd2);
endmodule

module sram_id_table_writer #(
  parameter int                    NUM_SLOTS  = 14,
  parameter int                    ID_WIDTH   = 16,
  parameter int                    ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] SLOT_BASE  = '0
) (
  input logic                   clk,
  input logic                   reset,
  sram_id_table_writer_if.slave bus
);
  localparam int SLOT_W = 4;

  localparam logic [1:0] ST_HIT     = 2'd0;
  localparam logic [1:0] ST_INSERT  = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_INVALID = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_EVAL, S_WRITE, S_RESP} state_e;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [1:0]        status;
  } resp_t;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [NUM_SLOTS-1:0]  ena_q, ena_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ID_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                  resp_valid_q, resp_valid_d;
  resp_t                 resp_q, resp_d;

  logic [NUM_SLOTS-1:0][1:0] code;
  logic [NUM_SLOTS-1:0]      is_match, is_empty;
  logic                      any_hit, any_empty, accept;
  logic [SLOT_W-1:0]         hit_slot, empty_slot;

  assign code = bus.comp_result;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sram_id_slot_dec u_dec (
      .code     (code[g]),
      .is_match (is_match[g]),
      .is_empty (is_empty[g])
    );
  end

  // Downward scan so the lowest index is the last (winning) assignment
  always_comb begin
    hit_slot   = '0;
    empty_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (is_match[i]) hit_slot   = SLOT_W'(i);
      if (is_empty[i]) empty_slot = SLOT_W'(i);
    end
  end

  assign any_hit       = |is_match;
  assign any_empty     = |is_empty;
  assign bus.req_ready = reset & (state_q == S_IDLE);
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      slot_q       <= '0;
      ena_q        <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      slot_q       <= slot_d;
      ena_q        <= ena_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = (bus.req_id == '0) ? S_RESP : S_COMPARE;
      S_COMPARE: state_d = S_EVAL;
      S_EVAL:    state_d = any_hit ? S_RESP : (any_empty ? S_WRITE : S_RESP);
      S_WRITE:   if (bus.sram_wr_ack) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    id_d         = id_q;
    slot_d       = slot_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    resp_d       = resp_q;
    ena_d        = (state_d == S_COMPARE) ? '1 : '0;
    wr_req_d     = (state_d == S_WRITE);
    resp_valid_d = (state_d == S_RESP);

    if (state_q == S_IDLE && accept) id_d = bus.req_id;

    if (state_q == S_EVAL && !any_hit && any_empty) begin
      slot_d    = empty_slot;
      wr_addr_d = SLOT_BASE + ADDR_WIDTH'(empty_slot);
      wr_data_d = id_q;
    end

    if (state_d == S_RESP) begin
      case (state_q)
        S_IDLE:  resp_d = '{slot: '0, status: ST_INVALID};
        S_EVAL:  resp_d = any_hit ? '{slot: hit_slot, status: ST_HIT}
                                  : '{slot: '0, status: ST_FULL};
        S_WRITE: resp_d = '{slot: slot_q, status: ST_INSERT};
        default: resp_d = resp_q;
      endcase
    end
  end

  assign bus.ena          = ena_q;
  assign bus.packet_in_ID = id_q;
  assign bus.sram_wr_req  = wr_req_q;
  assign bus.sram_wr_addr = wr_addr_q;
  assign bus.sram_wr_data = wr_data_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_slot    = resp_q.slot;
  assign bus.resp_status  = resp_q.status;
endmodule

// File: tb/tb_sram_id_table_writer.sv
// Bench for sram_id_table_writer: slot table + comparator + SRAM ack agent,
// a cycle-level expectation model, and directed requests with literal results.
module tb_sram_id_table_writer;
  localparam int             NS = 14;
  localparam int             IW = 16;
  localparam int             AW = 19;
  localparam logic [AW-1:0]  SB = 19'h7FFF8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sram_id_table_writer_if #(.NUM_SLOTS(NS), .ID_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  sram_id_table_writer #(.NUM_SLOTS(NS), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .SLOT_BASE(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- environment: slot contents, comparator, ack agent
  logic [IW-1:0] tab [NS];
  logic [NS-1:0] force3 = '0;
  int            ack_delay = 0;
  int            wr_wait = 0;
  bit            spurious_ack = 1'b0;

  function automatic logic [1:0] slot_code(input int i, input logic [IW-1:0] id);
    if (force3[i]) return 2'd3;
    if (tab[i] == '0) return 2'd2;
    return (tab[i] == id) ? 2'd1 : 2'd0;
  endfunction

  int env_idx;
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      if (bus.ena[i]) bus.comp_result[2*i +: 2] <= slot_code(i, bus.packet_in_ID);
    if (bus.sram_wr_req && bus.sram_wr_ack) begin
      env_idx = int'(AW'(bus.sram_wr_addr - SB));
      if (env_idx < NS) tab[env_idx] = bus.sram_wr_data;
    end
  end

  always @(negedge clk) begin
    if (bus.sram_wr_req) begin
      bus.sram_wr_ack = (wr_wait == ack_delay);
      wr_wait++;
    end else begin
      bus.sram_wr_ack = spurious_ack;
      wr_wait = 0;
    end
  end

  // ---------------- expectation model
  typedef enum int {K_HIT, K_INS, K_FULL, K_INV} kind_e;

  int            cyc = 0;
  bit            m_busy = 1'b0;
  kind_e         m_kind = K_HIT;
  int            m_t = 0;
  int            m_ack_cyc = 0;
  bit            m_acked = 1'b0;
  logic [3:0]    m_slot = '0;
  logic [1:0]    m_status = '0;
  logic [IW-1:0] m_id = '0;
  int            last_acc = 0;

  function automatic int m_resp_cyc();
    case (m_kind)
      K_INV:   return m_t + 1;
      K_INS:   return m_acked ? m_ack_cyc + 1 : -1;
      default: return m_t + 3;
    endcase
  endfunction

  task automatic classify(input logic [IW-1:0] id);
    int mi, ei;
    mi = -1; ei = -1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (slot_code(i, id) == 2'd1) mi = i;
      if (slot_code(i, id) == 2'd2) ei = i;
    end
    if (id == '0)     begin m_kind = K_INV;  m_slot = 4'd0;     m_status = 2'd3; end
    else if (mi >= 0) begin m_kind = K_HIT;  m_slot = 4'(mi);   m_status = 2'd0; end
    else if (ei >= 0) begin m_kind = K_INS;  m_slot = 4'(ei);   m_status = 2'd1; end
    else              begin m_kind = K_FULL; m_slot = 4'd0;     m_status = 2'd2; end
  endtask

  int mc;
  always @(posedge clk) begin
    mc = cyc;
    cyc++;
    if (!reset) m_busy = 1'b0;
    else if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy = 1'b1; m_t = mc; last_acc = mc; m_id = bus.req_id; m_acked = 1'b0;
        classify(bus.req_id);
      end
    end else if (m_kind == K_INS && !m_acked && mc >= m_t + 3 && bus.sram_wr_ack) begin
      m_acked = 1'b1; m_ack_cyc = mc;
    end else if (mc == m_resp_cyc()) m_busy = 1'b0;
  end

  // ---------------- per-cycle compare + monitors
  int            ena_cnt = 0, wr_cnt = 0, resp_cnt = 0, last_resp = 0;
  logic [3:0]    last_slot = '0;
  logic [1:0]    last_status = '0;
  logic [AW-1:0] last_wr_addr = '0;
  bit            e_ena, e_wr, e_rv;

  always @(posedge clk) begin
    #2;
    if (cyc >= 1) begin
      check("req_ready", 32'(bus.req_ready), 32'(reset && !m_busy));
      e_ena = m_busy && m_kind != K_INV && cyc == m_t + 1;
      check("ena", 32'(bus.ena), e_ena ? 32'h3FFF : 32'h0);
      if (m_busy && m_kind != K_INV && (cyc == m_t + 1 || cyc == m_t + 2))
        check("packet_in_ID", 32'(bus.packet_in_ID), 32'(m_id));
      e_wr = m_busy && m_kind == K_INS && cyc >= m_t + 3 && !m_acked;
      check("sram_wr_req", 32'(bus.sram_wr_req), 32'(e_wr));
      if (e_wr) begin
        check("sram_wr_addr", 32'(bus.sram_wr_addr), 32'(AW'(SB + AW'(m_slot))));
        check("sram_wr_data", 32'(bus.sram_wr_data), 32'(m_id));
      end
      e_rv = m_busy && cyc == m_resp_cyc();
      check("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
      if (e_rv) begin
        check("resp_slot", 32'(bus.resp_slot), 32'(m_slot));
        check("resp_status", 32'(bus.resp_status), 32'(m_status));
      end
    end
    if (bus.ena != '0) ena_cnt++;
    if (bus.sram_wr_req) begin wr_cnt++; last_wr_addr = bus.sram_wr_addr; end
    if (bus.resp_valid) begin
      resp_cnt++; last_slot = bus.resp_slot; last_status = bus.resp_status; last_resp = cyc;
    end
  end

  // ---------------- directed stimulus
  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check("ready wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic [IW-1:0] id);
    int n, n0;
    wait_ready();
    ena_cnt = 0; wr_cnt = 0;
    n0 = resp_cnt;
    bus.req_valid = 1'b1; bus.req_id = id;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_id = 16'hDEAD;
    n = 0;
    while (resp_cnt == n0 && n < 60) begin @(negedge clk); n++; end
    check("resp arrived", 32'(resp_cnt), 32'(n0 + 1));
  endtask

  task automatic expect_resp(input string tag, input logic [3:0] slot, input logic [1:0] st,
                             input int lat, input int wrs);
    check({tag, " slot"}, 32'(last_slot), 32'(slot));
    check({tag, " status"}, 32'(last_status), 32'(st));
    check({tag, " latency"}, 32'(last_resp - last_acc), 32'(lat));
    check({tag, " wr cycles"}, 32'(wr_cnt), 32'(wrs));
  endtask

  initial begin
    int n, n0;
    bus.req_valid = 1'b0;
    bus.req_id    = '0;
    for (int i = 0; i < NS; i++) tab[i] = '0;
    repeat (3) @(negedge clk);
    check("rst ena", 32'(bus.ena), 32'h0);
    check("rst packet_in_ID", 32'(bus.packet_in_ID), 32'h0);
    check("rst wr_req", 32'(bus.sram_wr_req), 32'h0);
    check("rst wr_addr", 32'(bus.sram_wr_addr), 32'h0);
    check("rst wr_data", 32'(bus.sram_wr_data), 32'h0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst resp_slot", 32'(bus.resp_slot), 32'h0);
    check("rst resp_status", 32'(bus.resp_status), 32'h0);
    check("rst req_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // hit in slot 5
    for (int i = 0; i < NS; i++) tab[i] = 16'h1000 + 16'(i);
    tab[5] = 16'h1234;
    do_req(16'h1234);
    expect_resp("hit", 4'd5, 2'd0, 3, 0);
    check("hit ena cycles", 32'(ena_cnt), 32'd1);

    // match beats a lower empty slot; stray ack ignored
    for (int i = 0; i < NS; i++) tab[i] = 16'h2000 + 16'(i);
    tab[2] = '0; tab[9] = 16'h00AB;
    spurious_ack = 1'b1;
    do_req(16'h00AB);
    spurious_ack = 1'b0;
    expect_resp("hit-over-empty", 4'd9, 2'd0, 3, 0);
    check("slot2 still empty", 32'(tab[2]), 32'h0);

    // insert with 3-cycle ack delay, then repeat hits
    for (int i = 0; i < NS; i++) tab[i] = 16'h3000 + 16'(i);
    tab[4] = '0; tab[7] = '0;
    ack_delay = 3;
    do_req(16'h0042);
    expect_resp("insert", 4'd4, 2'd1, 7, 4);
    check("insert addr", 32'(last_wr_addr), 32'h7FFFC);
    check("slot4 written", 32'(tab[4]), 32'h0042);
    check("slot7 untouched", 32'(tab[7]), 32'h0);
    ack_delay = 0;
    do_req(16'h0042);
    expect_resp("repeat hit", 4'd4, 2'd0, 3, 0);

    // full table; code 3 on the matching slot is not a match
    for (int i = 0; i < NS; i++) tab[i] = 16'h4000 + 16'(i);
    tab[6] = 16'h7777;
    force3[6] = 1'b1; force3[11] = 1'b1;
    do_req(16'h7777);
    force3 = '0;
    expect_resp("full", 4'd0, 2'd2, 3, 0);

    // minimum-latency insert into slot 13, address wraps past 2^19
    tab[13] = '0;
    do_req(16'h0BEE);
    expect_resp("wrap insert", 4'd13, 2'd1, 4, 1);
    check("wrap addr", 32'(last_wr_addr), 32'h00005);
    check("slot13 written", 32'(tab[13]), 32'h0BEE);

    // reserved ID 0
    do_req(16'h0000);
    expect_resp("invalid", 4'd0, 2'd3, 1, 0);
    check("invalid ena cycles", 32'(ena_cnt), 32'd0);

    // reset while waiting for ack
    tab[0] = '0;
    ack_delay = 1000;
    wait_ready();
    bus.req_valid = 1'b1; bus.req_id = 16'h5555;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.sram_wr_req && n < 20) begin @(negedge clk); n++; end
    check("wr_req before reset", 32'(bus.sram_wr_req), 32'd1);
    @(negedge clk);
    n0 = resp_cnt;
    reset = 1'b0;
    @(negedge clk);
    check("wr_req dropped by reset", 32'(bus.sram_wr_req), 32'd0);
    reset = 1'b1;
    ack_delay = 0;
    @(posedge clk); #1;
    check("ready after reset", 32'(bus.req_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("no resp after reset", 32'(resp_cnt), 32'(n0));
    check("slot0 not written", 32'(tab[0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
